// File: rtl/usb3_burst_rd_ctrl.sv
// FX3 slave-FIFO read-burst sequencer feeding the ram_cache write path.
// One burst per FX3 packet; returned words are re-timed by the FX3 read latency.
module usb3_burst_rd_ctrl #(
    parameter int         BURST_LEN  = 256,
    parameter int         RD_LATENCY = 2,
    parameter logic [1:0] FIFO_ADDR  = 2'b11,
    parameter int         IDLE_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        USB3_FLAGA,
    input  logic        cache_ready,
    input  logic [31:0] usb_data_in,
    output logic        usb_slcs_n,
    output logic        usb_sloe_n,
    output logic        usb_slrd_n,
    output logic [1:0]  usb_addr,
    output logic [3:0]  usb_rd_state,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        sof,
    output logic        burst_done,
    output logic [15:0] burst_cnt
);

    localparam int REQ_W  = $clog2(BURST_LEN + 1);
    localparam int WAIT_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FLAG1 = 4'd1,
        ST_FLAG2 = 4'd2,
        ST_SETUP = 4'd3,
        ST_READ  = 4'd6,
        ST_DRAIN = 4'd7,
        ST_GAP   = 4'd8
    } rd_state_t;

    rd_state_t             state_r;
    rd_state_t             next_state_s;
    logic [REQ_W-1:0]      req_cnt_r;
    logic [REQ_W-1:0]      rx_cnt_r;
    logic [WAIT_W-1:0]     wait_r;
    logic [RD_LATENCY-1:0] rd_pipe_r;
    logic [RD_LATENCY-1:0] rd_pipe_next_s;
    logic                  tap_s;
    logic                  bus_on_s;
    logic                  rd_on_s;
    logic                  slcs_n_r;
    logic                  sloe_n_r;
    logic                  slrd_n_r;
    logic [1:0]            addr_r;
    logic [31:0]           data_r;
    logic                  valid_r;
    logic                  sof_r;
    logic                  done_r;
    logic [15:0]           cnt_r;

    // Next-state decode; flag and arming inputs only matter before SETUP
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && USB3_FLAGA && cache_ready) next_state_s = ST_FLAG1;
                else                                     next_state_s = ST_IDLE;
            end
            ST_FLAG1: begin
                if (USB3_FLAGA) next_state_s = ST_FLAG2;
                else            next_state_s = ST_IDLE;
            end
            ST_FLAG2: begin
                if (USB3_FLAGA) next_state_s = ST_SETUP;
                else            next_state_s = ST_IDLE;
            end
            ST_SETUP: next_state_s = ST_READ;
            ST_READ: begin
                if (req_cnt_r == REQ_W'(BURST_LEN - 1)) next_state_s = ST_DRAIN;
                else                                    next_state_s = ST_READ;
            end
            ST_DRAIN: begin
                if (wait_r == WAIT_W'(RD_LATENCY - 1)) next_state_s = ST_GAP;
                else                                   next_state_s = ST_DRAIN;
            end
            ST_GAP: begin
                if (wait_r == WAIT_W'(IDLE_GAP - 1)) next_state_s = ST_IDLE;
                else                                 next_state_s = ST_GAP;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Pin strobes are decoded from the state being entered so the pin registers line up with state_r
    always_comb begin
        bus_on_s = 1'b0;
        rd_on_s  = 1'b0;
        case (next_state_s)
            ST_SETUP, ST_DRAIN: bus_on_s = 1'b1;
            ST_READ: begin
                bus_on_s = 1'b1;
                rd_on_s  = 1'b1;
            end
            default: begin
                bus_on_s = 1'b0;
                rd_on_s  = 1'b0;
            end
        endcase
    end

    // Read-latency shift of the asserted strobe; the oldest stage marks a word on the bus
    always_comb begin
        rd_pipe_next_s = rd_pipe_r;
        for (int i = RD_LATENCY - 1; i > 0; i--) begin
            rd_pipe_next_s[i] = rd_pipe_r[i-1];
        end
        rd_pipe_next_s[0] = ~slrd_n_r;
        tap_s             = rd_pipe_r[RD_LATENCY-1];
    end

    // State register with request and dwell counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            req_cnt_r <= {REQ_W{1'b0}};
            wait_r    <= {WAIT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_READ && next_state_s == ST_READ) req_cnt_r <= req_cnt_r + REQ_W'(1);
            else                                               req_cnt_r <= {REQ_W{1'b0}};
            if (next_state_s != state_r)                        wait_r <= {WAIT_W{1'b0}};
            else if (state_r == ST_DRAIN || state_r == ST_GAP)  wait_r <= wait_r + WAIT_W'(1);
            else                                                wait_r <= {WAIT_W{1'b0}};
        end
    end

    // FX3 pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            slcs_n_r <= 1'b1;
            sloe_n_r <= 1'b1;
            slrd_n_r <= 1'b1;
            addr_r   <= 2'b00;
        end else begin
            slcs_n_r <= ~bus_on_s;
            sloe_n_r <= ~bus_on_s;
            slrd_n_r <= ~rd_on_s;
            addr_r   <= bus_on_s ? FIFO_ADDR : 2'b00;
        end
    end

    // Word capture, framing pulses and completed-burst counter; rx count runs independently of requests
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe_r <= {RD_LATENCY{1'b0}};
            data_r    <= 32'd0;
            valid_r   <= 1'b0;
            sof_r     <= 1'b0;
            done_r    <= 1'b0;
            rx_cnt_r  <= {REQ_W{1'b0}};
            cnt_r     <= 16'd0;
        end else begin
            rd_pipe_r <= rd_pipe_next_s;
            valid_r   <= tap_s;
            sof_r     <= tap_s && (rx_cnt_r == {REQ_W{1'b0}});
            if (tap_s) data_r <= usb_data_in;
            else       data_r <= data_r;
            if (rx_cnt_r == REQ_W'(BURST_LEN)) begin
                rx_cnt_r <= {REQ_W{1'b0}};
                done_r   <= 1'b1;
                cnt_r    <= cnt_r + 16'd1;
            end else begin
                done_r <= 1'b0;
                cnt_r  <= cnt_r;
                if (tap_s) rx_cnt_r <= rx_cnt_r + REQ_W'(1);
                else       rx_cnt_r <= rx_cnt_r;
            end
        end
    end

    assign usb_slcs_n   = slcs_n_r;
    assign usb_sloe_n   = sloe_n_r;
    assign usb_slrd_n   = slrd_n_r;
    assign usb_addr     = addr_r;
    assign usb_rd_state = state_r;
    assign data_out     = data_r;
    assign data_valid   = valid_r;
    assign sof          = sof_r;
    assign burst_done   = done_r;
    assign burst_cnt    = cnt_r;

endmodule
